// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads the
// IF/ID pipeline register. Handles stall, branch flush/redirect and HALT freezing.
module fetch_stage #(
  parameter int unsigned          AddrWidth  = 16,
  parameter int unsigned          DataWidth  = 16,
  parameter logic [AddrWidth-1:0] ResetPC    = '0,
  parameter logic [3:0]           HaltOpcode = 4'hF,
  parameter logic [DataWidth-1:0] NopInstr   = '0,
  parameter int unsigned          CountWidth = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [AddrWidth-1:0]  branch_target,
  output logic [AddrWidth-1:0]  imem_addr,
  input  logic [DataWidth-1:0]  imem_data,
  output logic [DataWidth-1:0]  if_id_instr,
  output logic [AddrWidth-1:0]  if_id_pc1,
  output logic                  if_id_valid,
  output logic                  halted,
  output logic [CountWidth-1:0] fetch_count
);

  // What the stage does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_STALL,
    ACT_BUBBLE,
    ACT_FETCH
  } action_e;

  action_e                 action;
  logic [AddrWidth-1:0]    pc;
  logic [AddrWidth-1:0]    pc_plus1;
  logic                    is_halt;

  logic [AddrWidth-1:0]    pc_next;
  logic [DataWidth-1:0]    instr_next;
  logic [AddrWidth-1:0]    pc1_next;
  logic                    valid_next;
  logic                    halted_next;
  logic [CountWidth-1:0]   count_next;

  // The memory address is the PC itself, independent of stall or redirect.
  assign imem_addr = pc;
  // Modulo-2^AddrWidth increment: all-ones wraps to zero by design.
  assign pc_plus1  = pc + AddrWidth'(1);
  assign is_halt   = (imem_data[DataWidth-1 -: 4] == HaltOpcode);

  // Resolve priority: the older redirecting branch beats a stall on a younger instruction.
  always_comb begin
    if (branch_taken)  action = ACT_FLUSH;
    else if (stall)    action = ACT_STALL;
    else if (halted)   action = ACT_BUBBLE;
    else               action = ACT_FETCH;
  end

  // Next-state values for PC, IF/ID, halt flag and counter.
  always_comb begin
    // NOTE: every output gets a hold default first so no path can leave one unassigned and infer a latch.
    pc_next     = pc;
    instr_next  = if_id_instr;
    pc1_next    = if_id_pc1;
    valid_next  = if_id_valid;
    halted_next = halted;
    count_next  = fetch_count;
    unique case (action)
      ACT_FLUSH: begin
        pc_next     = branch_target;
        instr_next  = NopInstr;
        pc1_next    = '0;
        valid_next  = 1'b0;
        halted_next = 1'b0;   // a HALT fetched down the wrong path is discarded
      end
      ACT_STALL: ;            // everything holds
      ACT_BUBBLE: begin
        instr_next  = NopInstr;
        pc1_next    = '0;
        valid_next  = 1'b0;
      end
      ACT_FETCH: begin
        instr_next  = imem_data;
        pc1_next    = pc_plus1;
        valid_next  = 1'b1;
        count_next  = (&fetch_count) ? fetch_count : fetch_count + CountWidth'(1);
        if (is_halt) halted_next = 1'b1;   // PC freezes on the HALT word
        else         pc_next     = pc_plus1;
      end
      default: ;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc          <= ResetPC;
      if_id_instr <= NopInstr;
      if_id_pc1   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pc          <= pc_next;
      if_id_instr <= instr_next;
      if_id_pc1   <= pc1_next;
      if_id_valid <= valid_next;
      halted      <= halted_next;
      fetch_count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, streaming fetch, stall, flush,
// HALT freeze and release, PC wrap and asynchronous reset while stalled.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        halted;
  logic [15:0] fetch_count;

  // Second instance for the wrap-around reset-PC scenario.
  logic        rst_w;
  logic        stall_w;
  logic        branch_w;
  logic [15:0] target_w;
  logic [15:0] addr_w;
  logic [15:0] data_w;
  logic [15:0] instr_w;
  logic [15:0] pc1_w;
  logic        valid_w;
  logic        halted_w;
  logic [15:0] count_w;

  logic [15:0] imem [65536];

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [15:0] WA = 16'h1111, WB = 16'h2222, WC = 16'h3333, WD = 16'h4444;

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];
  assign data_w    = imem[addr_w];

  fetch_stage dut (
    .CLK(clk), .RST(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.ResetPC(16'hFFFF)) dut_w (
    .CLK(clk), .RST(rst_w), .stall(stall_w), .branch_taken(branch_w),
    .branch_target(target_w), .imem_addr(addr_w), .imem_data(data_w),
    .if_id_instr(instr_w), .if_id_pc1(pc1_w), .if_id_valid(valid_w),
    .halted(halted_w), .fetch_count(count_w)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the full observable state of the main instance.
  task automatic expect_state(input string name, input logic [15:0] addr,
                              input logic [15:0] instr, input logic [15:0] pc1,
                              input logic valid, input logic hlt, input logic [15:0] cnt);
    tests_run++;
    if ({imem_addr, if_id_instr, if_id_pc1, if_id_valid, halted, fetch_count} !==
        {addr, instr, pc1, valid, hlt, cnt}) begin
      tests_failed++;
      $display("FAIL %s: got addr=%h instr=%h pc1=%h valid=%b halted=%b count=%0d, expected addr=%h instr=%h pc1=%h valid=%b halted=%b count=%0d",
               name, imem_addr, if_id_instr, if_id_pc1, if_id_valid, halted, fetch_count,
               addr, instr, pc1, valid, hlt, cnt);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_state("reset_values", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    imem[0] = WA; imem[1] = WB; imem[2] = WC; imem[3] = WD;
    apply_reset();
    tick(); expect_state("stream_a", 16'h0001, WA, 16'h0001, 1'b1, 1'b0, 16'd1);
    tick(); expect_state("stream_b", 16'h0002, WB, 16'h0002, 1'b1, 1'b0, 16'd2);
    tick(); expect_state("stream_c", 16'h0003, WC, 16'h0003, 1'b1, 1'b0, 16'd3);
    tick(); expect_state("stream_d", 16'h0004, WD, 16'h0004, 1'b1, 1'b0, 16'd4);
  endtask

  task automatic test_stall();
    apply_reset();
    tick(); tick();
    expect_state("stall_pre", 16'h0002, WB, 16'h0002, 1'b1, 1'b0, 16'd2);
    stall = 1'b1;
    tick(); expect_state("stall_hold1", 16'h0002, WB, 16'h0002, 1'b1, 1'b0, 16'd2);
    tick(); expect_state("stall_hold2", 16'h0002, WB, 16'h0002, 1'b1, 1'b0, 16'd2);
    stall = 1'b0;
    tick(); expect_state("stall_rel_c", 16'h0003, WC, 16'h0003, 1'b1, 1'b0, 16'd3);
    tick(); expect_state("stall_rel_d", 16'h0004, WD, 16'h0004, 1'b1, 1'b0, 16'd4);
  endtask

  task automatic test_flush_over_stall();
    imem[16'h0010] = 16'h5A5A;
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 16'h0010;
    tick(); expect_state("flush_bubble", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd4);
    stall = 1'b0;
    branch_taken = 1'b0;
    tick(); expect_state("flush_target", 16'h0011, 16'h5A5A, 16'h0011, 1'b1, 1'b0, 16'd5);
  endtask

  task automatic test_halt();
    imem[2] = 16'hF000;
    imem[3] = WC;
    apply_reset();
    tick(); tick();
    expect_state("halt_pre", 16'h0002, WB, 16'h0002, 1'b1, 1'b0, 16'd2);
    tick(); expect_state("halt_word", 16'h0002, 16'hF000, 16'h0003, 1'b1, 1'b1, 16'd3);
    for (int i = 0; i < 5; i++) begin
      tick(); expect_state($sformatf("halt_bubble%0d", i), 16'h0002, 16'h0000, 16'h0000,
                           1'b0, 1'b1, 16'd3);
    end
    // A stall while halted must not disturb the frozen state.
    stall = 1'b1;
    tick(); expect_state("halt_stall", 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'd3);
    stall = 1'b0;
  endtask

  task automatic test_halt_release();
    imem[4] = 16'h7777;
    branch_taken = 1'b1;
    branch_target = 16'h0004;
    tick(); expect_state("release_flush", 16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd3);
    branch_taken = 1'b0;
    tick(); expect_state("release_fetch", 16'h0005, 16'h7777, 16'h0005, 1'b1, 1'b0, 16'd4);
  endtask

  task automatic test_wrap_and_async_reset();
    imem[16'hFFFF] = 16'h2468;
    imem[0] = WA;
    @(negedge clk);
    rst_w = 1'b0;
    stall_w = 1'b0;
    branch_w = 1'b0;
    target_w = '0;
    #2;
    tests_run++;
    if (addr_w !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL wrap_reset_pc: got %h expected ffff", addr_w);
    end
    rst_w = 1'b1;
    tick();
    tests_run++;
    if ({addr_w, instr_w, pc1_w, valid_w} !== {16'h0000, 16'h2468, 16'h0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_first: got addr=%h instr=%h pc1=%h valid=%b expected addr=0000 instr=2468 pc1=0000 valid=1",
               addr_w, instr_w, pc1_w, valid_w);
    end
    tick();
    tests_run++;
    if ({addr_w, instr_w, pc1_w, count_w} !== {16'h0001, WA, 16'h0001, 16'd2}) begin
      tests_failed++;
      $display("FAIL wrap_second: got addr=%h instr=%h pc1=%h count=%0d expected addr=0001 instr=%h pc1=0001 count=2",
               addr_w, instr_w, pc1_w, count_w, WA);
    end
    stall_w = 1'b1;
    tick();
    #3;
    rst_w = 1'b0;   // between edges, while stalled
    #1;
    tests_run++;
    if ({addr_w, instr_w, pc1_w, valid_w, halted_w, count_w} !==
        {16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL async_reset: got addr=%h instr=%h pc1=%h valid=%b halted=%b count=%0d expected addr=ffff zeros",
               addr_w, instr_w, pc1_w, valid_w, halted_w, count_w);
    end
    @(negedge clk);
    rst_w = 1'b1;
    stall_w = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    rst_w = 1'b0;
    stall_w = 1'b0;
    branch_w = 1'b0;
    target_w = '0;
    #12;
    rst = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_flush_over_stall();
    test_halt();
    test_halt_release();
    test_wrap_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
